// File: rtl/conv_weight_regfile.sv
// Double-buffered weight/bias register file for a conv layer: SHIFT/BIAS words fill a
// shadow bank, which is copied to the output-driving active bank once a full kernel lands.
module conv_weight_regfile #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int PTR_WIDTH   = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [2:0]                                  current_state,
  input  logic [DATA_WIDTH-1:0]                       i_weight,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] o_weight_bank,
  output logic [DATA_WIDTH-1:0]                       o_bias,
  output logic                                        o_weight_valid,
  output logic                                        o_commit,
  output logic                                        o_err
);

  localparam int NW = KERNEL_SIZE * KERNEL_SIZE;
  localparam logic [PTR_WIDTH-1:0] NW_PTR = PTR_WIDTH'(NW);

  localparam logic [2:0] ST_PRELOAD = 3'd1;
  localparam logic [2:0] ST_LOAD    = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_BIAS    = 3'd4;

  logic [NW*DATA_WIDTH-1:0] shadow_bank;
  logic [DATA_WIDTH-1:0]    shadow_bias;
  logic [PTR_WIDTH-1:0]     wr_ptr;
  logic                     shift_d;
  logic                     bias_d;
  logic                     bias_d_p1;
  logic                     commit_p0;
  logic                     err_flag;
  logic                     load_req;

  assign load_req = (current_state == ST_LOAD) || (current_state == ST_PRELOAD);
  assign o_err    = err_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_d        <= 1'b0;
      bias_d         <= 1'b0;
      bias_d_p1      <= 1'b0;
      commit_p0      <= 1'b0;
      wr_ptr         <= '0;
      err_flag       <= 1'b0;
      shadow_bank    <= '0;
      shadow_bias    <= '0;
      o_weight_bank  <= '0;
      o_bias         <= '0;
      o_weight_valid <= 1'b0;
      o_commit       <= 1'b0;
    end else begin
      // Stage p0: state decode registered to line up with the lagged i_weight
      shift_d   <= (current_state == ST_SHIFT);
      bias_d    <= (current_state == ST_BIAS);
      bias_d_p1 <= bias_d;

      // Stage p1: copy of the shadow bank captured one cycle after the first BIAS word
      commit_p0 <= 1'b0;
      o_commit  <= commit_p0;
      if (commit_p0) begin
        o_weight_bank  <= shadow_bank;
        o_bias         <= shadow_bias;
        o_weight_valid <= 1'b1;
      end

      // A reload request wins over any in-flight shift/bias write, which is dropped
      if (load_req) begin
        wr_ptr   <= '0;
        err_flag <= 1'b0;
      end else if (shift_d) begin
        if (wr_ptr < NW_PTR) begin
          for (int k = 0; k < NW; k++) begin
            if (wr_ptr == PTR_WIDTH'(k)) shadow_bank[k*DATA_WIDTH +: DATA_WIDTH] <= i_weight;
          end
          wr_ptr <= wr_ptr + 1'b1;
        end else begin
          err_flag <= 1'b1;
        end
      end else if (bias_d) begin
        shadow_bias <= i_weight;
        if (wr_ptr == NW_PTR) begin
          if (!bias_d_p1) commit_p0 <= 1'b1;
        end else begin
          err_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/conv_weight_regfile.md
CONV_WEIGHT_REGFILE -- requirements
Module: conv_weight_regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one weight/bias word.
REQ-002 Parameter KERNEL_SIZE, default 3; kernel holds KERNEL_SIZE*KERNEL_SIZE (NW, default 9) weights.
REQ-003 Parameter PTR_WIDTH, default 4, width of write pointer; SHALL satisfy 2**PTR_WIDTH > NW.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 current_state  input  3  conv-layer FSM state, same bus that drives the weight buffer.
REQ-007 i_weight  input  DATA_WIDTH  registered weight/bias word from the weight buffer, valid one cycle after the matching state.
REQ-008 o_weight_bank  output  NW*DATA_WIDTH  active kernel weights, word k at bits [k*DATA_WIDTH +: DATA_WIDTH], k=0 first received.
REQ-009 o_bias  output  DATA_WIDTH  active kernel bias.
REQ-010 o_weight_valid  output  1  active bank holds a committed kernel.
REQ-011 o_commit  output  1  one-cycle pulse when shadow bank is copied to active bank.
REQ-012 o_err  output  1  sticky: load sequence delivered a weight count other than NW.

Function
REQ-013 State codes SHALL be: IDLE=0, PRELOAD=1, LOAD=2, SHIFT=3, BIAS=4; 5-7 treated as IDLE.
REQ-014 Block SHALL register shift_d = (current_state==SHIFT) and bias_d = (current_state==BIAS), aligning with the one-cycle latency of i_weight.
REQ-015 Block SHALL hold a shadow bank (NW words + bias) and an active bank; only the active bank drives outputs.
REQ-016 On shift_d with wr_ptr < NW: shadow[wr_ptr] <= i_weight, wr_ptr <= wr_ptr+1.
REQ-017 On shift_d with wr_ptr == NW: word discarded, wr_ptr holds, err_flag set.
REQ-018 On bias_d: shadow bias <= i_weight; if wr_ptr == NW, next cycle active bank <= shadow bank, o_commit=1 for exactly one cycle, o_weight_valid <= 1.
REQ-019 On bias_d with wr_ptr != NW: no commit, active bank and o_weight_valid unchanged, err_flag set.
REQ-020 Consecutive bias_d cycles SHALL each overwrite shadow bias; commit fires once per BIAS-run (on its first cycle) only.
REQ-021 current_state==LOAD or PRELOAD SHALL clear wr_ptr and err_flag in the same cycle; has priority over a pending shift_d/bias_d write, which is dropped.
REQ-022 LOAD/PRELOAD SHALL NOT clear the active bank or o_weight_valid (compute continues on old kernel during reload).
REQ-023 o_err SHALL equal err_flag; remains set until LOAD/PRELOAD or reset.
REQ-024 In IDLE and reserved states all registers hold.
REQ-025 No arithmetic beyond the pointer increment; pointer SHALL never exceed NW.

Reset
REQ-026 rst_n low SHALL immediately force: wr_ptr=0, shift_d=bias_d=0, both banks and o_bias all-zero, o_weight_valid=0, o_commit=0, o_err=0.
REQ-027 Reset asserted mid-SHIFT SHALL discard all partial shadow contents; after release the block waits for LOAD/PRELOAD-agnostic SHIFT data starting at wr_ptr=0.

Verification
REQ-028 PRELOAD, 9 SHIFT with i_weight 1..9 (lagged one cycle), 1 BIAS with 0xA -> o_commit one pulse, o_weight_bank words 0..8 = 1..9, o_bias=0xA, o_weight_valid=1, o_err=0.
REQ-029 After REQ-028, LOAD, 5 SHIFT (0x11..0x15), BIAS 0x1F -> no commit, bank still 1..9, bias 0xA, o_err=1; next LOAD -> o_err=0.
REQ-030 LOAD, 11 SHIFT (0x21..0x2B), BIAS 0x2F -> words 0..8 = 0x21..0x29, o_err=1, commit still fires with bias 0x2F.
REQ-031 During reload, sample o_weight_bank every cycle from LOAD through last SHIFT -> constant old kernel until the commit cycle, then new kernel.
REQ-032 rst_n pulsed low after 4th SHIFT -> all outputs zero asynchronously; full 9+1 sequence afterwards commits correctly.
REQ-033 BIAS held 3 cycles with words 0x31,0x32,0x33 after 9 shifts -> exactly one o_commit pulse, o_bias=0x31 at commit; shadow bias ends 0x33 (committed on next sequence only).
